instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 182 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks instruction memory 0..prog_len-1 through a 2-entry skid buffer.
// Optional halt-opcode termination is compiled in with `define IFETCH_HALT_EN.
module instr_fetch #(
    parameter  int ADDR_WIDTH      = 10,
    parameter  int OPCODE_WIDTH    = 3,
    parameter  int IMEM_ADDR_WIDTH = 8,
    localparam int INS_WIDTH       = OPCODE_WIDTH + 3*ADDR_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [IMEM_ADDR_WIDTH:0]   prog_len,
    output logic                       busy,
    output logic                       done,
    output logic                       imem_rd_en,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [INS_WIDTH-1:0]       imem_rdata,
    output logic [INS_WIDTH-1:0]       instruction,
    output logic                       ins_valid,
    input  logic                       ins_ready,
    output logic [IMEM_ADDR_WIDTH-1:0] pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                       state_r;
    logic [IMEM_ADDR_WIDTH:0]     len_r;
    logic [IMEM_ADDR_WIDTH:0]     fptr_r;
    logic                         busy_r;
    logic                         done_r;
    logic                         halted_r;
    logic                         inflight_r;
    logic [IMEM_ADDR_WIDTH-1:0]   ret_addr_r;
    logic [INS_WIDTH-1:0]         buf_data_r [2];
    logic [IMEM_ADDR_WIDTH-1:0]   buf_addr_r [2];
    logic                         wr_ptr_r;
    logic                         rd_ptr_r;
    logic [1:0]                   count_r;

    logic                         pop_s;
    logic                         push_s;
    logic                         halt_s;
    logic                         issue_s;
    logic [2:0]                   occ_s;
    logic [1:0]                   count_nxt_s;

    // Handshake, halt detection, read-issue credit and next buffer occupancy.
    always_comb begin
        pop_s       = 1'b0;
        halt_s      = 1'b0;
        push_s      = 1'b0;
        issue_s     = 1'b0;
        occ_s       = 3'd0;
        count_nxt_s = 2'd0;

        if (count_r != 2'd0) begin
            pop_s = ins_ready;
        end else begin
            pop_s = 1'b0;
        end

`ifdef IFETCH_HALT_EN
        if (inflight_r && !halted_r &&
            (imem_rdata[INS_WIDTH-1 -: OPCODE_WIDTH] == {OPCODE_WIDTH{1'b1}})) begin
            halt_s = 1'b1;
        end else begin
            halt_s = 1'b0;
        end
`else
        halt_s = 1'b0;
`endif

        // Returns after a halt belong to reads issued past the end of the program.
        push_s = inflight_r && !halted_r && !halt_s;

        occ_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        if ((state_r == ST_RUN) && (fptr_r < len_r) && (occ_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end

        count_nxt_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
    end

    // Control FSM with registered busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            len_r    <= {(IMEM_ADDR_WIDTH+1){1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r  <= ST_RUN;
                        len_r    <= prog_len;
                        busy_r   <= 1'b1;
                        halted_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (halt_s) begin
                        state_r  <= ST_DRAIN;
                        halted_r <= 1'b1;
                    end else if (fptr_r == len_r) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // No reads issue here, so an empty next buffer means nothing is left in flight.
                    if (count_nxt_s == 2'd0) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Fetch pointer, in-flight tracking and the 2-entry instruction buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fptr_r     <= {(IMEM_ADDR_WIDTH+1){1'b0}};
            inflight_r <= 1'b0;
            ret_addr_r <= {IMEM_ADDR_WIDTH{1'b0}};
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_r[i] <= {INS_WIDTH{1'b0}};
                buf_addr_r[i] <= {IMEM_ADDR_WIDTH{1'b0}};
            end
        end else begin
            if ((state_r == ST_IDLE) && start) begin
                fptr_r <= {(IMEM_ADDR_WIDTH+1){1'b0}};
            end else if (issue_s) begin
                fptr_r <= fptr_r + {{IMEM_ADDR_WIDTH{1'b0}}, 1'b1};
            end
            inflight_r <= issue_s;
            if (issue_s) begin
                ret_addr_r <= fptr_r[IMEM_ADDR_WIDTH-1:0];
            end
            if (push_s) begin
                buf_data_r[wr_ptr_r] <= imem_rdata;
                buf_addr_r[wr_ptr_r] <= ret_addr_r;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_nxt_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign imem_rd_en  = issue_s;
    assign imem_addr   = fptr_r[IMEM_ADDR_WIDTH-1:0];
    assign instruction = buf_data_r[rd_ptr_r];
    assign pc          = buf_addr_r[rd_ptr_r];
    assign ins_valid   = (count_r != 2'd0);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected {pc, word} pairs are queued at start, popped on transfer.
module tb_instr_fetch;

    localparam int IAW = 8;
    localparam int IW  = 34;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [IAW:0]   prog_len;
    logic           busy, done, imem_rd_en, ins_valid, ins_ready;
    logic [IAW-1:0] imem_addr, pc;
    logic [IW-1:0]  imem_rdata, instruction;

    logic [IW-1:0]      mem [256];
    logic [IAW+IW-1:0]  exp_q [$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, s0 = 0, rel = 0;
    bit mon_en = 1'b0;
    int first_xfer, last_xfer, nxfer, ndone, done_cyc, busy_fall, nrd, nrd_at8;
    bit busy_prev;

    instr_fetch dut (
        .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
        .busy(busy), .done(done), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instruction(instruction), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .pc(pc)
    );

    always #5 clk = ~clk;

    // Instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (time %0t)", tag, act, exp, $time);
    endtask

    // Output monitor: scoreboard compare whenever a word is presented, plus event bookkeeping.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            rel = cyc - s0;
            if (ins_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_word", 64'd1, 64'd0);
                end else begin
                    check_val("instruction", instruction, exp_q[0][IW-1:0]);
                    check_val("pc", pc, exp_q[0][IAW+IW-1:IW]);
                    if (ins_ready) begin
                        void'(exp_q.pop_front());
                        nxfer++;
                        if (first_xfer < 0) first_xfer = rel;
                        last_xfer = rel;
                    end
                end
            end
            if (done) begin
                ndone++;
                done_cyc = rel;
            end
            if (imem_rd_en) nrd++;
            if (rel == 8) nrd_at8 = nrd;
            if (busy_prev && !busy) busy_fall = rel;
            busy_prev = busy;
        end
    end

    task automatic setup(input int nexp);
        exp_q.delete();
        for (int i = 0; i < nexp; i++) exp_q.push_back({IAW'(i), mem[i]});
        first_xfer = -1; last_xfer = -1; nxfer = 0; ndone = 0;
        done_cyc = -1; busy_fall = -1; nrd = 0; nrd_at8 = -1; busy_prev = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic run_prog(input int len, input int lo, input int hi, input int rs_cyc, input int nexp);
        int r;
        setup(nexp);
        @(posedge clk); #1;
        start = 1'b1; prog_len = (IAW+1)'(len); ins_ready = 1'b1; s0 = cyc;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            r = cyc - s0;
            start     = (r == rs_cyc);
            prog_len  = (r == rs_cyc) ? 9'd7 : (IAW+1)'(len);
            ins_ready = !(r >= lo && r <= hi);
        end
        mon_en = 1'b0;
        check_val("q_empty", exp_q.size(), 64'd0);
        check_val("n_xfer", nxfer, nexp);
        check_val("n_done", ndone, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, busy, 64'd0);
        check_val({tag, "_done"}, done, 64'd0);
        check_val({tag, "_rd_en"}, imem_rd_en, 64'd0);
        check_val({tag, "_addr"}, imem_addr, 64'd0);
        check_val({tag, "_valid"}, ins_valid, 64'd0);
        check_val({tag, "_instr"}, instruction, 64'd0);
        check_val({tag, "_pc"}, pc, 64'd0);
    endtask

    initial begin
        logic [IW-1:0] saved;
        rst = 1'b1; start = 1'b0; ins_ready = 1'b1; prog_len = '0; imem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = {3'($urandom_range(0, 6)), 31'($urandom)};
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic 4-word program, ready always high.
        run_prog(4, 99, 99, -1, 4);
        check_val("t1_first_valid", first_xfer, 64'd3);
        check_val("t1_last_valid", last_xfer, 64'd6);
        check_val("t1_done_cyc", done_cyc, 64'd7);
        check_val("t1_busy_fall", busy_fall, 64'd8);
        check_val("t1_reads", nrd, 64'd4);

        // Downstream stall for cycles 3..8.
        run_prog(5, 3, 8, -1, 5);
        check_val("t2_reads_in_stall", nrd_at8, 64'd2);
        check_val("t2_first_xfer", first_xfer, 64'd9);
        check_val("t2_reads", nrd, 64'd5);

        // Empty program.
        run_prog(0, 99, 99, -1, 0);
        check_val("t3_reads", nrd, 64'd0);
        check_val("t3_done_cyc", done_cyc, 64'd3);

        // Second start during RUN with a larger prog_len is ignored.
        run_prog(4, 99, 99, 2, 4);
        check_val("t4_reads", nrd, 64'd4);

        // Halt opcode at word 2.
        saved  = mem[2];
        mem[2] = {3'b111, 31'($urandom)};
`ifdef IFETCH_HALT_EN
        run_prog(6, 99, 99, -1, 2);
        check_val("t5_reads", nrd, 64'd4);
        check_val("t5_done_cyc", done_cyc, 64'd6);
`else
        run_prog(6, 99, 99, -1, 6);
        check_val("t5_reads", nrd, 64'd6);
        check_val("t5_done_cyc", done_cyc, 64'd9);
`endif
        mem[2] = saved;

        // Reset with two words buffered, then a fresh 2-word program.
        setup(5);
        @(posedge clk); #1;
        start = 1'b1; prog_len = 9'd5; ins_ready = 1'b0; s0 = cyc;
        repeat (5) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check_val("t6_pre_valid", ins_valid, 64'd1);
        check_val("t6_pre_busy", busy, 64'd1);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; ins_ready = 1'b1;
        run_prog(2, 99, 99, -1, 2);
        check_val("t6_reads", nrd, 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
